// File: rtl/ad_pnchk_if.sv
// Link-side bundle of the PN checker: received word/qualifier in, sync and error status out.
interface ad_pnchk_if #(
    parameter int unsigned DW        = 16,
    parameter int unsigned ERR_CNT_W = 32
);
    logic                 valid;
    logic [DW-1:0]        data_in;
    logic                 clr_count;
    logic                 pn_oos;
    logic                 pn_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output valid, data_in, clr_count,
        input  pn_oos, pn_err, err_count
    );

    modport slave (
        input  valid, data_in, clr_count,
        output pn_oos, pn_err, err_count
    );
endinterface

// File: rtl/ad_pnchk.sv
// Parallel PN sequence checker: self-seeds from rx data in SEARCH, free-runs once LOCKED.
// Optional AD_PNCHK_BIT_ERR_EN: err_count accumulates mismatching bits instead of words.
module ad_pnchk #(
    parameter logic [31:0] POL_MASK       = 32'h000000C0,
    parameter int unsigned POL_W          = 7,
    parameter int unsigned DW             = 16,
    parameter int unsigned LOCK_THRESHOLD = 16,
    parameter int unsigned OOS_THRESHOLD  = 8,
    parameter int unsigned ERR_CNT_W      = 32
) (
    input logic       clk,
    input logic       reset,
    ad_pnchk_if.slave pn
);
    localparam int unsigned PN_W = (DW > POL_W) ? DW : POL_W;
    localparam int unsigned FW   = POL_W + DW;
    localparam int unsigned IW   = $clog2(DW + 1);
    localparam int unsigned SW   = ERR_CNT_W + IW + 1;
    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e               state_q, state_d;
    logic [PN_W-1:0]      hist_q, hist_d;
    logic [7:0]           match_cnt_q, match_cnt_d;
    logic [7:0]           miss_cnt_q, miss_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 pn_err_q, pn_err_d;
    logic                 pn_oos_q, pn_oos_d;

    logic [DW-1:0]        expected;
    logic                 mismatch;
    logic [IW-1:0]        err_inc;
    logic [SW-1:0]        err_sum;
    logic [7:0]           match_inc, miss_inc;

    // Walk from the oldest bit down so each expected bit sees the ones generated before it.
    always_comb begin
        logic [FW-1:0] full;
        full = {hist_q[POL_W-1:0], {DW{1'b0}}};
        for (int i = DW - 1; i >= 0; i--) begin
            full[i] = ^(full[i +: POL_W+1] & POL_MASK[POL_W:0]);
        end
        expected = full[DW-1:0];
    end

    assign mismatch = (pn.data_in != expected) || (pn.data_in == '0);

`ifdef AD_PNCHK_BIT_ERR_EN
    always_comb begin
        logic [DW-1:0] diff;
        diff    = pn.data_in ^ expected;
        err_inc = '0;
        for (int i = 0; i < DW; i++) begin
            err_inc = err_inc + IW'(diff[i]);
        end
        if (err_inc == '0) err_inc = IW'(1);
    end
`else
    assign err_inc = IW'(1);
`endif

    assign err_sum   = SW'(err_cnt_q) + SW'(err_inc);
    assign match_inc = match_cnt_q + 8'd1;
    assign miss_inc  = miss_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        pn_err_d    = 1'b0;

        if (pn.valid) begin
            pn_err_d = mismatch;
            case (state_q)
                StSearch: begin
                    hist_d = PN_W'({hist_q, pn.data_in});
                    if (mismatch) begin
                        match_cnt_d = '0;
                    end else if (match_inc == 8'(LOCK_THRESHOLD)) begin
                        state_d     = StLocked;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        match_cnt_d = match_inc;
                    end
                end
                StLocked: begin
                    // Free-run on our own prediction so rx errors never pollute the history.
                    hist_d = PN_W'({hist_q, expected});
                    if (mismatch) begin
                        err_cnt_d = (err_sum > SW'(CntMax)) ? CntMax : err_sum[ERR_CNT_W-1:0];
                        if (miss_inc == 8'(OOS_THRESHOLD)) begin
                            state_d     = StSearch;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        if (pn.clr_count) err_cnt_d = '0;
        pn_oos_d = (state_d == StSearch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSearch;
            hist_q      <= '1;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            pn_err_q    <= 1'b0;
            pn_oos_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            pn_err_q    <= pn_err_d;
            pn_oos_q    <= pn_oos_d;
        end
    end

    assign pn.pn_oos    = pn_oos_q;
    assign pn.pn_err    = pn_err_q;
    assign pn.err_count = err_cnt_q;
endmodule

// File: tb/tb_ad_pnchk.sv
// Directed bench for ad_pnchk: serial PN7 reference stream, 32-bit and 4-bit counter instances.
module tb_ad_pnchk;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ad_pnchk_if #(.DW(16), .ERR_CNT_W(32)) bus  ();
    ad_pnchk_if #(.DW(16), .ERR_CNT_W(4))  bus4 ();

    assign bus4.valid     = bus.valid;
    assign bus4.data_in   = bus.data_in;
    assign bus4.clr_count = bus.clr_count;

    ad_pnchk #(.DW(16), .ERR_CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .pn    (bus)
    );

    ad_pnchk #(.DW(16), .ERR_CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .pn    (bus4)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [6:0]  gh;
    logic [15:0] w;
    int          exp_err;
    int          exp_err4;
    int          bit_inc;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Serial PN7 x^7+x^6+1: gh[0] newest bit, gh[6] seven bits ago.
    task automatic gen_word(output logic [15:0] word);
        logic b;
        word = '0;
        for (int k = 0; k < 16; k++) begin
            b    = gh[6] ^ gh[5];
            gh   = {gh[5:0], b};
            word = {word[14:0], b};
        end
    endtask

    task automatic send(input logic [15:0] d, input logic v);
        bus.data_in = d;
        bus.valid   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.valid     = 1'b0;
        bus.clr_count = 1'b0;
        bus.data_in   = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        gh    = 7'h7f;
    endtask

    task automatic check_err(input string tag);
        check_eq({tag, "_cnt"}, 64'(bus.err_count), 64'(exp_err));
        check_eq({tag, "_cnt4"}, 64'(bus4.err_count), 64'(exp_err4));
    endtask

    initial begin
`ifdef AD_PNCHK_BIT_ERR_EN
        bit_inc = 3;
`else
        bit_inc = 1;
`endif
        // Reset state
        do_reset();
        check_eq("rst_oos", 64'(bus.pn_oos), 64'd1);
        check_eq("rst_err", 64'(bus.pn_err), 64'd0);
        exp_err  = 0;
        exp_err4 = 0;
        check_err("rst");

        // Clean stream from the phase following 1111111 matches from the first word
        for (int k = 1; k <= 16; k++) begin
            gen_word(w);
            send(w, 1'b1);
            check_eq($sformatf("lock_oos_%0d", k), 64'(bus.pn_oos), (k < 16) ? 64'd1 : 64'd0);
            check_eq($sformatf("lock_err_%0d", k), 64'(bus.pn_err), 64'd0);
        end

        // Single bit-3 error while locked
        gen_word(w);
        send(w, 1'b1);
        check_eq("clean_err", 64'(bus.pn_err), 64'd0);
        gen_word(w);
        send(w ^ 16'h0008, 1'b1);
        exp_err  = 1;
        exp_err4 = 1;
        check_eq("single_err", 64'(bus.pn_err), 64'd1);
        check_eq("single_oos", 64'(bus.pn_oos), 64'd0);
        check_err("single");
        gen_word(w);
        send(w, 1'b1);
        check_eq("after_err", 64'(bus.pn_err), 64'd0);
        check_eq("after_oos", 64'(bus.pn_oos), 64'd0);
        check_err("after");

        // 19 more isolated errors: 4-bit counter saturates at 15
        for (int k = 0; k < 19; k++) begin
            gen_word(w);
            send(w ^ 16'h0008, 1'b1);
            exp_err++;
            if (exp_err4 < 15) exp_err4++;
            check_err($sformatf("sat_%0d", k));
            gen_word(w);
            send(w, 1'b1);
            check_eq($sformatf("sat_oos_%0d", k), 64'(bus.pn_oos), 64'd0);
        end
        check_eq("sat_final4", 64'(bus4.err_count), 64'd15);
        check_eq("sat_final", 64'(bus.err_count), 64'd20);

        // Clear wins over a same-cycle increment
        gen_word(w);
        bus.clr_count = 1'b1;
        send(w ^ 16'h0008, 1'b1);
        bus.clr_count = 1'b0;
        exp_err  = 0;
        exp_err4 = 0;
        check_eq("clr_perr", 64'(bus.pn_err), 64'd1);
        check_err("clr");

        // Three flipped bits in one locked word
        gen_word(w);
        send(w ^ 16'h0111, 1'b1);
        exp_err  = bit_inc;
        exp_err4 = bit_inc;
        check_eq("bits_perr", 64'(bus.pn_err), 64'd1);
        check_err("bits");
        gen_word(w);
        send(w, 1'b1);

        // 8 consecutive corrupt words drop lock on the 8th
        for (int k = 1; k <= 8; k++) begin
            gen_word(w);
            send(w ^ 16'h0008, 1'b1);
            exp_err++;
            exp_err4++;
            check_eq($sformatf("oos_run_%0d", k), 64'(bus.pn_oos), (k == 8) ? 64'd1 : 64'd0);
        end
        check_err("oos_run");
        // Relock in 16 clean words; nothing counted in SEARCH
        for (int k = 1; k <= 16; k++) begin
            gen_word(w);
            send(w, 1'b1);
            check_eq($sformatf("relock_oos_%0d", k), 64'(bus.pn_oos), (k < 16) ? 64'd1 : 64'd0);
            check_eq($sformatf("relock_err_%0d", k), 64'(bus.pn_err), 64'd0);
        end
        check_err("relock");

        // Gapped valid: same lock point in valid words, no pn_err in gaps
        do_reset();
        exp_err  = 0;
        exp_err4 = 0;
        for (int k = 1; k <= 16; k++) begin
            gen_word(w);
            send(w, 1'b1);
            check_eq($sformatf("gap_oos_%0d", k), 64'(bus.pn_oos), (k < 16) ? 64'd1 : 64'd0);
            send(~w, 1'b0);
            check_eq($sformatf("gap_perr_%0d", k), 64'(bus.pn_err), 64'd0);
            check_eq($sformatf("gap_hold_%0d", k), 64'(bus.pn_oos), (k < 16) ? 64'd1 : 64'd0);
        end
        check_err("gap");

        // Stuck-low input: never locks, errors every cycle, nothing counted
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            send(16'h0000, 1'b1);
            check_eq($sformatf("zero_perr_%0d", k), 64'(bus.pn_err), 64'd1);
            check_eq($sformatf("zero_oos_%0d", k), 64'(bus.pn_oos), 64'd1);
        end
        check_err("zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
